// File: rtl/pool_1_fmap_buffer.sv
// Single-map feature buffer between conv_2d and pool_1: fills once from the
// producer, then serves 1-cycle-latency reads until pool_1 releases it.
module pool_1_fmap_buffer #(
   parameter int FMAP_H = 35,
   parameter int FMAP_W = 35,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              conv_2d_wr_en,
   input  logic [DATA_W-1:0] conv_2d_data_in,
   input  logic [ADDR_W-1:0] conv_2d_data_addr,
   input  logic              pool_1_rd_en,
   input  logic [ADDR_W-1:0] pool_1_rd_addr,
   output logic [DATA_W-1:0] pool_1_rd_data,
   output logic              pool_1_rd_valid,
   output logic              buf_full,
   input  logic              pool_1_done,
   output logic              wr_err
);

   localparam int N      = FMAP_H * FMAP_W;
   localparam int MEM_AW = (N > 1) ? $clog2(N) : 1;
   localparam logic [ADDR_W-1:0] N_A = ADDR_W'(N);
   localparam logic [15:0]       N_C = 16'(N);

   typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

   state_t            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              wr_err_q, wr_err_d;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              wr_ok, rd_ok;

   logic [DATA_W-1:0] mem [N];

   assign wr_ok = conv_2d_wr_en && (conv_2d_data_addr < N_A) && (state_q != FULL);
   assign rd_ok = pool_1_rd_en && (state_q == FULL);

   // Counter is zero in IDLE, so IDLE and FILL share the same accept path.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_err_d = wr_err_q | (conv_2d_wr_en & ~wr_ok);
      unique case (state_q)
         IDLE, FILL: begin
            if (wr_ok) begin
               cnt_d   = cnt_q + 16'd1;
               state_d = (cnt_q + 16'd1 == N_C) ? FULL : FILL;
            end
         end
         FULL: begin
            if (pool_1_done) begin
               state_d = IDLE;
               cnt_d   = 16'd0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 16'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 16'd0;
         wr_err_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wr_err_q   <= wr_err_d;
         rd_valid_q <= rd_ok;
         if (rd_ok)
            rd_data_q <= (pool_1_rd_addr < N_A) ? mem[pool_1_rd_addr[MEM_AW-1:0]] : '0;
      end
   end

   // Storage is never cleared; the next fill overwrites it.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok)
         mem[conv_2d_data_addr[MEM_AW-1:0]] <= conv_2d_data_in;
   end

   assign pool_1_rd_data  = rd_data_q;
   assign pool_1_rd_valid = rd_valid_q;
   assign buf_full        = (state_q == FULL);
   assign wr_err          = wr_err_q;

endmodule

// File: tb/tb_pool_1_fmap_buffer.sv
// Random + directed stimulus for pool_1_fmap_buffer checked every cycle
// against a map-level model (pixel array, write count, full/err flags).
module tb_pool_1_fmap_buffer;
   localparam int H = 35, W = 35, DW = 16, AW = 16;
   localparam int N = H * W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          we = 1'b0, re = 1'b0, dn = 1'b0;
   logic [DW-1:0] wd = '0;
   logic [AW-1:0] wa = '0, ra = '0;
   logic [DW-1:0] rd_data;
   logic          rd_valid, full, err;

   always #5 clk = ~clk;

   pool_1_fmap_buffer #(.FMAP_H(H), .FMAP_W(W), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .conv_2d_wr_en(we), .conv_2d_data_in(wd), .conv_2d_data_addr(wa),
      .pool_1_rd_en(re), .pool_1_rd_addr(ra),
      .pool_1_rd_data(rd_data), .pool_1_rd_valid(rd_valid),
      .buf_full(full), .pool_1_done(dn), .wr_err(err)
   );

   // model state
   int        m_mem [N];
   int        m_cnt;
   bit        m_full, m_err, m_valid;
   int        m_data;
   int        n_cmp = 0, n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_edge();
      bit was_full;
      was_full = m_full;
      if (rst) begin
         m_cnt = 0; m_full = 0; m_err = 0; m_valid = 0; m_data = 0;
      end else begin
         m_valid = re && was_full;
         if (m_valid) m_data = (int'(ra) < N) ? m_mem[ra] : 0;
         if (we) begin
            if (was_full || int'(wa) >= N) m_err = 1;
            else begin
               m_mem[wa] = int'(wd);
               m_cnt++;
               if (m_cnt == N) m_full = 1;
            end
         end
         if (dn && was_full) begin m_full = 0; m_cnt = 0; end
      end
   endtask

   // Apply one cycle of inputs, advance model and DUT, then compare all outputs.
   task automatic step(input bit r, input bit w, input int a, input int d,
                       input bit rd, input int radr, input bit done);
      rst = r; we = w; wa = AW'(a); wd = DW'(d); re = rd; ra = AW'(radr); dn = done;
      @(posedge clk);
      model_edge();
      #1;
      chk("buf_full", 32'(full), 32'(m_full));
      chk("wr_err", 32'(err), 32'(m_err));
      chk("rd_valid", 32'(rd_valid), 32'(m_valid));
      chk("rd_data", 32'(rd_data), 32'(m_data));
   endtask

   task automatic idle(); step(0, 0, 0, 0, 0, 0, 0); endtask

   initial begin
      int guard, nwr;
      foreach (m_mem[i]) m_mem[i] = 0;
      m_cnt = 0; m_full = 0; m_err = 0; m_valid = 0; m_data = 0;

      // reset
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("lit_rst_full", 32'(full), 0);
      chk("lit_rst_data", 32'(rd_data), 0);

      // sequential fill, data = addr+1
      for (int i = 0; i < N; i++) begin
         step(0, 1, i, i + 1, 0, 0, 0);
         if (i == N - 2) chk("lit_full_before_last", 32'(full), 0);
      end
      chk("lit_full_after_last", 32'(full), 1);
      chk("lit_err_clean_fill", 32'(err), 0);

      // back-to-back reads incl. out-of-range
      step(0, 0, 0, 0, 1, 0, 0);    chk("lit_rd0", 32'(rd_data), 1);
      step(0, 0, 0, 0, 1, 612, 0);  chk("lit_rd612", 32'(rd_data), 613);
      step(0, 0, 0, 0, 1, 1224, 0); chk("lit_rd1224", 32'(rd_data), 1225);
      step(0, 0, 0, 0, 1, 2000, 0); chk("lit_rd2000", 32'(rd_data), 0);
      chk("lit_rd2000_v", 32'(rd_valid), 1);
      idle();
      chk("lit_no_rd_v", 32'(rd_valid), 0);

      // release with simultaneous read
      step(0, 0, 0, 0, 1, 5, 1);
      chk("lit_done_rd5", 32'(rd_data), 6);
      chk("lit_done_full", 32'(full), 0);

      // reads while IDLE hold data
      step(0, 0, 0, 0, 1, 7, 0);
      step(0, 0, 0, 0, 1, 9, 0);
      chk("lit_idle_rd_v", 32'(rd_valid), 0);
      chk("lit_idle_rd_hold", 32'(rd_data), 6);

      // random fill with stray reads/done; inject an out-of-range write mid-fill
      guard = 0; nwr = 0;
      while (!m_full && guard < 20000) begin
         if (nwr == 10) begin
            step(0, 1, N, 16'hDEAD, 0, 0, 0);
            chk("lit_oor_err", 32'(err), 1);
            nwr++;
         end else begin
            bit w;
            w = ($urandom_range(0, 3) != 0);
            if (w) nwr++;
            step(0, w, $urandom_range(0, N - 1), $urandom_range(0, 65535),
                 $urandom_range(0, 3) == 0, $urandom_range(0, N - 1), $urandom_range(0, 7) == 0);
         end
         guard++;
      end
      chk("rand_fill_reached_full", 32'(full), 1);
      chk("lit_err_sticky", 32'(err), 1);

      // write while full is dropped; random reads
      step(0, 1, 3, 16'hBEEF, 0, 0, 0);
      step(0, 0, 0, 0, 1, 3, 0);
      for (int i = 0; i < 60; i++)
         step(0, 0, 0, 0, $urandom_range(0, 1), $urandom_range(0, N + 40), 0);

      // done + write same cycle
      step(0, 1, 4, 16'h1234, 0, 0, 1);
      chk("lit_done_wr_full", 32'(full), 0);
      chk("lit_done_wr_err", 32'(err), 1);

      // reset mid-fill discards progress
      for (int i = 0; i < 600; i++) step(0, 1, i, $urandom_range(0, 65535), 0, 0, 0);
      step(1, 1, 600, 0, 1, 0, 0);
      chk("lit_rst_mid_full", 32'(full), 0);
      chk("lit_rst_mid_err", 32'(err), 0);
      chk("lit_rst_mid_v", 32'(rd_valid), 0);
      chk("lit_rst_mid_data", 32'(rd_data), 0);
      for (int i = 0; i < N; i++) begin
         step(0, 1, N - 1 - i, $urandom_range(0, 65535), 0, 0, 0);
         if (i == N - 2) chk("lit_refill_before_last", 32'(full), 0);
      end
      chk("lit_refill_full", 32'(full), 1);
      for (int i = 0; i < 40; i++)
         step(0, 0, 0, 0, 1, $urandom_range(0, N - 1), 0);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pool_1_fmap_buffer.md
POOL_1_FMAP_BUFFER -- requirements
Module: pool_1_fmap_buffer

Interface
REQ-001 Parameter FMAP_H, default 35: feature-map rows.
REQ-002 Parameter FMAP_W, default 35: feature-map columns.
REQ-003 Parameter DATA_W, default 16: pixel width.
REQ-004 Parameter ADDR_W, default 16: address width.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 conv_2d_wr_en  input  1  write strobe from conv_2d.
REQ-009 conv_2d_data_in  input  DATA_W  pixel to store.
REQ-010 conv_2d_data_addr  input  ADDR_W  linear pixel address, row*FMAP_W+col.
REQ-011 pool_1_rd_en  input  1  read strobe from pool_1.
REQ-012 pool_1_rd_addr  input  ADDR_W  linear read address.
REQ-013 pool_1_rd_data  output  DATA_W  read data.
REQ-014 pool_1_rd_valid  output  1  rd_data valid this cycle.
REQ-015 buf_full  output  1  full map stored; drives pool_1_layer_enable.
REQ-016 pool_1_done  input  1  pool_1 finished; releases buffer.
REQ-017 wr_err  output  1  sticky error flag.

Function
REQ-018 The block SHALL hold FMAP_H*FMAP_W words of DATA_W storage (N = 1225 at defaults).
REQ-019 The FSM SHALL have states IDLE, FILL, FULL; buf_full = 1 exactly when state is FULL.
REQ-020 A write is accepted when conv_2d_wr_en = 1, addr < N, and state is IDLE or FILL; accepted writes store data at addr at that edge.
REQ-021 IDLE -> FILL on the first accepted write; the 16-bit write counter becomes 1.
REQ-022 In FILL, each accepted write increments the counter; duplicate addresses are counted again, no coverage tracking.
REQ-023 The accepted write that brings the counter to N SHALL move the FSM to FULL; buf_full rises on the same edge, visible the following cycle.
REQ-024 Writes with addr >= N SHALL be dropped, not counted, and set wr_err.
REQ-025 Writes in FULL SHALL be dropped and set wr_err.
REQ-026 wr_err is sticky and cleared only by rst.
REQ-027 Reads are served only in FULL: pool_1_rd_en = 1 at edge k gives pool_1_rd_data = mem[rd_addr] and pool_1_rd_valid = 1 after edge k+1 (1-cycle latency); a read every cycle is allowed.
REQ-028 A read in FULL with rd_addr >= N SHALL return 0 with pool_1_rd_valid = 1.
REQ-029 A read outside FULL SHALL give pool_1_rd_valid = 0 and leave pool_1_rd_data unchanged.
REQ-030 pool_1_rd_valid SHALL be 0 in any cycle not following an accepted read.
REQ-031 pool_1_done = 1 in FULL SHALL move the FSM to IDLE and clear the counter; buf_full falls the next cycle.
REQ-032 pool_1_done outside FULL SHALL be ignored.
REQ-033 pool_1_done and pool_1_rd_en in the same FULL cycle: the read SHALL be served, then the FSM returns to IDLE.
REQ-034 pool_1_done and conv_2d_wr_en in the same FULL cycle: the write SHALL be dropped and wr_err set; the next write after IDLE starts a new fill.
REQ-035 Memory contents SHALL NOT be cleared on release or reset; they are overwritten by the next fill.

Reset
REQ-036 On rst = 1 at a clock edge: state IDLE, counter 0, buf_full 0, pool_1_rd_valid 0, pool_1_rd_data 0, wr_err 0.
REQ-037 rst SHALL take priority over all other inputs, including mid-FILL and mid-read; a partial fill is discarded.

Verification
REQ-038 Write addr 0..1224 with data = addr+1, one per cycle -> buf_full = 0 through write 1224, buf_full = 1 the cycle after write 1225, wr_err = 0.
REQ-039 After full, read addr 0, 612, 1224 back-to-back -> rd_data 1, 613, 1225 with rd_valid = 1 on the three cycles following the strobes; read addr 2000 -> rd_data 0, rd_valid 1.
REQ-040 Write addr 1225 during FILL -> counter unchanged, wr_err = 1 and stays set; write while FULL -> mem unchanged, wr_err = 1.
REQ-041 pool_1_done with rd_en at addr 5 in FULL -> rd_data 6, rd_valid 1 next cycle; buf_full 0 next cycle; a second 1225-write fill reasserts buf_full.
REQ-042 Assert rst after 600 writes -> all outputs 0; a new 1225-write sequence is then needed before buf_full = 1.
REQ-043 Read strobes in IDLE and FILL -> rd_valid stays 0 and rd_data holds its last value.
